// File: rtl/inv_srl_cell_pkg.sv
// inv_srl_cell_pkg: shared depth limits and width helpers for the invertible-pin shift register
package inv_srl_cell_pkg;

    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 32;

    // Tap-address width; never narrower than one bit so the A port always exists
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Fill-count width; must be able to hold the value DEPTH itself
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/inv_srl_cell_inv_pin.sv
// inv_pin: optional static inversion of one invertible input pin
module inv_pin #(
    parameter logic [0:0] INV = 1'b0
) (
    input  logic I,
    output logic O
);

    assign O = I ^ INV;

endmodule

// File: rtl/inv_srl_cell.sv
// inv_srl_cell: addressable shift register with invertible D/CE/CLR pins; fill counter enabled by INV_SRL_CELL_FILL_EN
module inv_srl_cell
    import inv_srl_cell_pkg::*;
#(
    parameter logic [0:0] INV_D   = 1'b0,
    parameter logic [0:0] INV_CE  = 1'b0,
    parameter logic [0:0] INV_CLR = 1'b0,
    parameter int         DEPTH   = 16
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    (* invertible_pin = "INV_D" *)
    input  logic                       D,
    (* invertible_pin = "INV_CE" *)
    input  logic                       CE,
    (* invertible_pin = "INV_CLR" *)
    input  logic                       CLR,
    input  logic [addr_w(DEPTH)-1:0]   A,
    output logic                       Q,
    output logic                       Q_LAST,
    output logic [cnt_w(DEPTH)-1:0]    CNT,
    output logic                       FULL
);

    localparam int AW = addr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic d_e;
    logic ce_e;
    logic clr_e;

    inv_pin #(.INV(INV_D))   u_inv_d   (.I(D),   .O(d_e));
    inv_pin #(.INV(INV_CE))  u_inv_ce  (.I(CE),  .O(ce_e));
    inv_pin #(.INV(INV_CLR)) u_inv_clr (.I(CLR), .O(clr_e));

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift toward the tail when enabled; CLR never touches the data
    always_comb begin
        sr_d = ce_e ? {sr_q[DEPTH-2:0], d_e} : sr_q;
    end

    // Taps read straight from the register; addresses past the tail read 0
    always_comb begin
        Q      = (int'(A) < DEPTH) ? sr_q[A] : 1'b0;
        Q_LAST = sr_q[DEPTH-1];
    end

`ifdef INV_SRL_CELL_FILL_EN
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear beats increment; increment saturates at DEPTH
    always_comb begin
        cnt_d = clr_e ? '0 :
                (ce_e && cnt_q != CW'(DEPTH)) ? cnt_q + CW'(1) : cnt_q;
    end

    // Data and fill count share the synchronous reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign CNT  = cnt_q;
    assign FULL = (cnt_q == CW'(DEPTH));
`else
    // Without the fill counter CLR has no effect, so its decoded level is dropped
    logic unused_clr;
    assign unused_clr = clr_e;

    // Data register only
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign CNT  = '0;
    assign FULL = 1'b0;
`endif

endmodule

// File: tb/tb_inv_srl_cell.sv
// tb_inv_srl_cell: directed checks of shift, taps, fill counter, inversion and reset
module tb_inv_srl_cell;

`ifdef INV_SRL_CELL_FILL_EN
    localparam logic FILL = 1'b1;
`else
    localparam logic FILL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, d, ce, clr;
    logic [3:0] a;
    logic       q, q_last, full;
    logic [4:0] cnt;

    logic       d2, ce2;
    logic [3:0] a2;
    logic       q2, q_last2, full2;
    logic [4:0] cnt2;

    int total = 0;
    int bad   = 0;

    logic [19:0] pat = 20'hB53C9;

    always #5 clk = ~clk;

    inv_srl_cell #(.INV_D(1'b0), .INV_CE(1'b0), .INV_CLR(1'b0), .DEPTH(16)) u_dut (
        .CLK(clk), .RST_N(rst_n), .D(d), .CE(ce), .CLR(clr), .A(a),
        .Q(q), .Q_LAST(q_last), .CNT(cnt), .FULL(full)
    );

    inv_srl_cell #(.INV_D(1'b1), .INV_CE(1'b1), .INV_CLR(1'b0), .DEPTH(16)) u_inv (
        .CLK(clk), .RST_N(rst_n), .D(d2), .CE(ce2), .CLR(clr), .A(a2),
        .Q(q2), .Q_LAST(q_last2), .CNT(cnt2), .FULL(full2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ecnt(input int n);
        return FILL ? 32'(n) : 32'd0;
    endfunction

    initial begin
        rst_n = 1'b0; d = 1'b0; ce = 1'b0; clr = 1'b0; a = 4'd0;
        d2 = 1'b0; ce2 = 1'b1; a2 = 4'd0;
        step();
        step();
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_qlast", 32'(q_last), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_full", 32'(full), 32'd0);

        rst_n = 1'b1; ce = 1'b1;
        d = 1'b1; step();
        d = 1'b0; step();
        d = 1'b1; step();
        d = 1'b1; step();
        ce = 1'b0;
        a = 4'd0; #1 chk("shift_a0", 32'(q), 32'd1);
        a = 4'd1; #1 chk("shift_a1", 32'(q), 32'd1);
        a = 4'd2; #1 chk("shift_a2", 32'(q), 32'd0);
        a = 4'd3; #1 chk("shift_a3", 32'(q), 32'd1);
        a = 4'd4; #1 chk("shift_a4", 32'(q), 32'd0);
        chk("shift_cnt", 32'(cnt), ecnt(4));

        d = 1'b0; step();
        a = 4'd0; #1 chk("hold_a0", 32'(q), 32'd1);
        a = 4'd3; #1 chk("hold_a3", 32'(q), 32'd1);
        chk("hold_cnt", 32'(cnt), ecnt(4));

        ce = 1'b1; d = 1'b0; step();
        chk("pre_clr_cnt", 32'(cnt), ecnt(5));
        clr = 1'b1; d = 1'b1; step();
        clr = 1'b0; ce = 1'b0;
        chk("clr_cnt", 32'(cnt), 32'd0);
        a = 4'd0; #1 chk("clr_shift_a0", 32'(q), 32'd1);
        a = 4'd1; #1 chk("clr_shift_a1", 32'(q), 32'd0);
        a = 4'd2; #1 chk("clr_shift_a2", 32'(q), 32'd1);

        rst_n = 1'b0; step();
        rst_n = 1'b1; ce = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            d = pat[k-1];
            step();
            chk($sformatf("sat_cnt_%0d", k), 32'(cnt), ecnt(k < 16 ? k : 16));
            chk($sformatf("sat_full_%0d", k), 32'(full), (FILL && k >= 16) ? 32'd1 : 32'd0);
            chk($sformatf("sat_qlast_%0d", k), 32'(q_last), k >= 16 ? 32'(pat[k-16]) : 32'd0);
        end
        ce = 1'b0;
        a = 4'd0; #1 chk("sat_a0", 32'(q), 32'(pat[19]));
        a = 4'd15; #1 chk("sat_a15", 32'(q), 32'(pat[4]));

        rst_n = 1'b0; step();
        rst_n = 1'b1; ce = 1'b1; d = 1'b1;
        for (int k = 0; k < 9; k++) step();
        chk("mid_cnt9", 32'(cnt), ecnt(9));
        rst_n = 1'b0; step();
        rst_n = 1'b1; ce = 1'b0;
        for (int k = 0; k < 16; k++) begin
            a = 4'(k);
            #1 chk($sformatf("midrst_a%0d", k), 32'(q), 32'd0);
        end
        chk("midrst_cnt", 32'(cnt), 32'd0);
        chk("midrst_full", 32'(full), 32'd0);
        ce = 1'b1; d = 1'b1; step();
        ce = 1'b0;
        chk("resume_cnt", 32'(cnt), ecnt(1));
        a = 4'd0; #1 chk("resume_a0", 32'(q), 32'd1);

        ce2 = 1'b0; d2 = 1'b0;
        step(); step(); step();
        ce2 = 1'b1;
        chk("inv_cnt", 32'(cnt2), ecnt(3));
        a2 = 4'd0; #1 chk("inv_a0", 32'(q2), 32'd1);
        a2 = 4'd1; #1 chk("inv_a1", 32'(q2), 32'd1);
        a2 = 4'd2; #1 chk("inv_a2", 32'(q2), 32'd1);
        a2 = 4'd3; #1 chk("inv_a3", 32'(q2), 32'd0);
        d2 = 1'b1; step(); step();
        chk("inv_hold_cnt", 32'(cnt2), ecnt(3));
        a2 = 4'd2; #1 chk("inv_hold_a2", 32'(q2), 32'd1);
        a2 = 4'd3; #1 chk("inv_hold_a3", 32'(q2), 32'd0);
        chk("inv_hold_full", 32'(full2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
